// File: rtl/arbiter_request_mux_pkg.sv
// Shared definitions for the arbiter request funnel.
//   clog2               : ceiling log2 helper used to size selects, pointers and counts
//   ARB_REQ_MUX_HEADROOM: FIFO slots held back for beats granted while arb_enable is low
//   fifo_count_t        : occupancy type for the default FIFO depth (0..DEPTH inclusive)
//   fifo_state_e        : FIFO occupancy class
//   headroom_e          : arbiter throttle state
package arbiter_request_mux_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // The arbiter can keep granting for up to 3 cycles after arb_enable falls.
    localparam int ARB_REQ_MUX_HEADROOM   = 3;
    localparam int ARB_REQ_MUX_FIFO_DEPTH = 8;

    typedef logic [clog2(ARB_REQ_MUX_FIFO_DEPTH):0] fifo_count_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

    typedef enum logic {
        HR_THROTTLED = 1'b0,
        HR_ENABLED   = 1'b1
    } headroom_e;

endpackage

// File: rtl/arbiter_request_mux_if.sv
// Handshake bundle between the input channels, the tree arbiter and the
// downstream consumer of the funnel.
//   in_valid/in_data/in_ready        : per-channel beat handshake (channel i at [i*DATA_W +: DATA_W])
//   arb_req/arb_enable               : request vector and enable towards the arbiter
//   arb_grant/arb_select/arb_valid   : registered grant returned by the arbiter
//   out_valid/out_data/out_ready     : output beat handshake
// slave  : the funnel's view
// master : the environment's view (channels, arbiter and consumer)
interface arbiter_request_mux_if #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 64
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        arb_req;
    logic                     arb_enable;
    logic [NUM_CH-1:0]        arb_grant;
    logic [SEL_W-1:0]         arb_select;
    logic                     arb_valid;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_ready;

    modport slave (
        input  in_valid, in_data, arb_grant, arb_select, arb_valid, out_ready,
        output in_ready, arb_req, arb_enable, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, arb_grant, arb_select, arb_valid, out_ready,
        input  in_ready, arb_req, arb_enable, out_valid, out_data
    );
endinterface

// File: rtl/arbiter_request_mux_fifo.sv
// Synchronous first-word-fall-through FIFO with explicit occupancy counter.
//   ap_clk, areset      : clock, asynchronous active-high reset (drops contents)
//   push, push_data     : write strobe and data (ignored when full)
//   full                : count == DEPTH
//   rd_valid, rd_data   : head entry, valid whenever not empty (data reads 0 when empty)
//   rd_ready            : consumer accepts the head entry
//   count               : current occupancy, 0..DEPTH
module arbiter_request_mux_fifo
    import arbiter_request_mux_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 8,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             ap_clk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    fifo_state_e      state;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        if (count_q == '0) begin
            state = FIFO_EMPTY;
        end else if (count_q == CNT_W'(DEPTH)) begin
            state = FIFO_FULL;
        end else begin
            state = FIFO_PARTIAL;
        end
    end

    assign full     = (state == FIFO_FULL);
    assign rd_valid = (state != FIFO_EMPTY);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign count    = count_q;

    assign wr_en = push && !full;
    assign rd_en = rd_valid && rd_ready;

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/arbiter_request_mux.sv
// N-to-1 request funnel around the tree arbiter. Presents the channel valids
// to the arbiter, accepts one beat per cycle from the granted channel into an
// output FIFO, and throttles the arbiter early enough that grants arriving
// after the throttle still fit.
//   ap_clk, areset : clock, asynchronous active-high reset
//   bus            : channel / arbiter / output handshake bundle (slave view)
//   fifo_count     : output FIFO occupancy
//   err_grant      : sticky flag, grant vector disagreed with encoded select
module arbiter_request_mux
    import arbiter_request_mux_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int SEL_W      = 2,
    parameter  int DATA_W     = 64,
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = clog2(FIFO_DEPTH) + 1
) (
    input  logic               ap_clk,
    input  logic               areset,
    arbiter_request_mux_if.slave bus,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               err_grant
);

    // Highest committed occupancy that still leaves room for the beat being
    // written plus every grant the arbiter may still issue after throttling.
    localparam int HEADROOM_LIMIT = FIFO_DEPTH - ARB_REQ_MUX_HEADROOM - 1;

    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] sel_onehot;
    logic [DATA_W-1:0] sel_data;
    logic              fifo_full;
    logic              take;
    logic [CNT_W:0]    committed;
    headroom_e         hr_state;

    assign sel        = bus.arb_select;
    assign sel_onehot = NUM_CH'(1) << sel;
    assign sel_data   = bus.in_data[int'(sel)*DATA_W +: DATA_W];

    // A grant to a channel that has since dropped valid is simply ignored.
    assign take = !areset && bus.arb_valid && bus.arb_grant[sel]
               && bus.in_valid[sel] && !fifo_full;

    assign bus.in_ready = take ? sel_onehot : '0;
    assign bus.arb_req  = areset ? '0 : bus.in_valid;

    arbiter_request_mux_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .push      (take),
        .push_data (sel_data),
        .full      (fifo_full),
        .rd_valid  (bus.out_valid),
        .rd_data   (bus.out_data),
        .rd_ready  (bus.out_ready),
        .count     (fifo_count)
    );

    // Pops are deliberately not credited: only the current count plus this
    // cycle's write decide whether the arbiter may keep granting.
    assign committed = {1'b0, fifo_count} + {{CNT_W{1'b0}}, take};

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            hr_state <= HR_THROTTLED;
        end else if (committed <= (CNT_W+1)'(HEADROOM_LIMIT)) begin
            hr_state <= HR_ENABLED;
        end else begin
            hr_state <= HR_THROTTLED;
        end
    end

    assign bus.arb_enable = (hr_state == HR_ENABLED);

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            err_grant <= 1'b0;
        end else if (bus.arb_valid && (bus.arb_grant != sel_onehot)) begin
            err_grant <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arbiter_request_mux.sv
module tb_arbiter_request_mux;

    localparam int NUM_CH     = 4;
    localparam int SEL_W      = 2;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 4;

    logic             ap_clk = 1'b0;
    logic             areset;
    logic [CNT_W-1:0] fifo_count;
    logic             err_grant;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] chan_data [NUM_CH];

    arbiter_request_mux_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

    arbiter_request_mux #(
        .NUM_CH     (NUM_CH),
        .SEL_W      (SEL_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .ap_clk     (ap_clk),
        .areset     (areset),
        .bus        (bus),
        .fifo_count (fifo_count),
        .err_grant  (err_grant)
    );

    initial forever #5 ap_clk = ~ap_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of beats the FIFO must hold, throttle and error flag.
    logic [DATA_W-1:0] exp_q [$];
    logic              m_en  = 1'b0;
    logic              m_err = 1'b0;

    always @(negedge ap_clk) begin : model
        int                s;
        logic              m_take;
        logic [NUM_CH-1:0] m_ready;
        logic [NUM_CH-1:0] m_onehot;
        int                occ;
        if (areset) begin
            exp_q.delete();
            m_en  = 1'b0;
            m_err = 1'b0;
            check("rst_in_ready",  64'(bus.in_ready),  64'd0);
            check("rst_arb_req",   64'(bus.arb_req),   64'd0);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_data",  64'(bus.out_data),  64'd0);
            check("rst_count",     64'(fifo_count),    64'd0);
            check("rst_enable",    64'(bus.arb_enable),64'd0);
            check("rst_err",       64'(err_grant),     64'd0);
        end else begin
            s        = int'(bus.arb_select);
            occ      = exp_q.size();
            m_onehot = '0;
            m_onehot[s] = 1'b1;
            m_take   = bus.arb_valid && bus.arb_grant[s] && bus.in_valid[s] && (occ < FIFO_DEPTH);
            m_ready  = m_take ? m_onehot : '0;
            check("in_ready",   64'(bus.in_ready),   64'(m_ready));
            check("ready_1hot", 64'($onehot0(bus.in_ready)), 64'd1);
            check("arb_req",    64'(bus.arb_req),    64'(bus.in_valid));
            check("out_valid",  64'(bus.out_valid),  64'(occ != 0));
            if (occ != 0) check("out_data", 64'(bus.out_data), 64'(exp_q[0]));
            check("fifo_count", 64'(fifo_count),     64'(occ));
            check("arb_enable", 64'(bus.arb_enable), 64'(m_en));
            check("err_grant",  64'(err_grant),      64'(m_err));
            // state after the coming edge
            if (bus.arb_valid && (bus.arb_grant != m_onehot)) m_err = 1'b1;
            m_en = (occ + (m_take ? 1 : 0)) <= (FIFO_DEPTH - 4);
            if (occ != 0 && bus.out_ready) void'(exp_q.pop_front());
            if (m_take) exp_q.push_back(bus.in_data[s*DATA_W +: DATA_W]);
        end
    end

    task automatic drive_data();
        for (int i = 0; i < NUM_CH; i++) bus.in_data[i*DATA_W +: DATA_W] = chan_data[i];
    endtask

    // One clock: remember which channels were accepted, advance their data after the edge.
    task automatic step();
        logic [NUM_CH-1:0] rdy;
        @(negedge ap_clk);
        rdy = bus.in_ready;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) if (rdy[i]) chan_data[i] = chan_data[i] + 64'd1;
        drive_data();
    endtask

    task automatic set_arb(input logic vld, input int sel);
        bus.arb_valid  = vld;
        bus.arb_select = SEL_W'(sel);
        bus.arb_grant  = NUM_CH'(1) << sel;
    endtask

    initial begin
        areset        = 1'b1;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        set_arb(1'b0, 0);
        for (int i = 0; i < NUM_CH; i++) chan_data[i] = 64'(i) << 56;
        drive_data();
        repeat (2) @(posedge ap_clk);
        #1;
        areset = 1'b0;
        step();
        check("lit_enable_after_rst", 64'(bus.arb_enable), 64'd1);

        // single channel, ch2
        chan_data[2] = 64'hAAAA_AAAA_AAAA_AAAA;
        drive_data();
        bus.in_valid = 4'b0100;
        set_arb(1'b1, 2);
        #1;
        check("lit_t1_ready", 64'(bus.in_ready), 64'h4);
        check("lit_t1_ov0",   64'(bus.out_valid), 64'd0);
        step();
        bus.in_valid = '0;
        set_arb(1'b0, 0);
        #1;
        check("lit_t1_ov1",   64'(bus.out_valid), 64'd1);
        check("lit_t1_data",  64'(bus.out_data), 64'hAAAA_AAAA_AAAA_AAAA);
        check("lit_t1_cnt1",  64'(fifo_count), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("lit_t1_cnt0",  64'(fifo_count), 64'd0);

        // rotating grants, free-flowing output
        bus.in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            set_arb(1'b1, k % 4);
            #1;
            check("lit_tp_ready", 64'(bus.in_ready), 64'(1) << (k % 4));
            step();
        end
        set_arb(1'b0, 0);
        repeat (2) step();
        check("lit_tp_drained", 64'(fifo_count), 64'd0);

        // backpressure: throttle at 5, three lagging grants, then full
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_arb(1'b1, k % 4);
            step();
        end
        check("lit_thr_cnt5", 64'(fifo_count), 64'd5);
        check("lit_thr_en0",  64'(bus.arb_enable), 64'd0);
        for (int k = 5; k < 8; k++) begin
            set_arb(1'b1, k % 4);
            step();
        end
        check("lit_thr_cnt8", 64'(fifo_count), 64'd8);
        set_arb(1'b1, 0);
        #1;
        check("lit_full_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("lit_full_cnt8", 64'(fifo_count), 64'd8);
        set_arb(1'b0, 0);
        bus.out_ready = 1'b1;
        repeat (9) step();
        check("lit_thr_drained", 64'(fifo_count), 64'd0);

        // stale grant
        bus.in_valid = 4'b1101;
        set_arb(1'b1, 1);
        #1;
        check("lit_stale_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("lit_stale_cnt", 64'(fifo_count), 64'd0);
        check("lit_stale_err", 64'(err_grant), 64'd0);

        // grant/select mismatch
        bus.in_valid   = 4'b1000;
        bus.arb_valid  = 1'b1;
        bus.arb_select = 2'd3;
        bus.arb_grant  = 4'b0001;
        #1;
        check("lit_mm_ready", 64'(bus.in_ready), 64'd0);
        check("lit_mm_err0",  64'(err_grant), 64'd0);
        step();
        set_arb(1'b0, 0);
        bus.in_valid = '0;
        #1;
        check("lit_mm_err1", 64'(err_grant), 64'd1);
        repeat (3) step();
        check("lit_mm_sticky", 64'(err_grant), 64'd1);

        // reset with count 5
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            set_arb(1'b1, (k + 1) % 4);
            step();
        end
        check("lit_pre_rst_cnt", 64'(fifo_count), 64'd5);
        set_arb(1'b1, 1);
        #1;
        areset = 1'b1;
        #1;
        check("lit_arst_ov",    64'(bus.out_valid), 64'd0);
        check("lit_arst_cnt",   64'(fifo_count), 64'd0);
        check("lit_arst_ready", 64'(bus.in_ready), 64'd0);
        check("lit_arst_err",   64'(err_grant), 64'd0);
        check("lit_arst_en",    64'(bus.arb_enable), 64'd0);
        step();
        areset = 1'b0;
        set_arb(1'b1, 0);
        #1;
        check("lit_post_ready", 64'(bus.in_ready), 64'd1);
        step();
        set_arb(1'b0, 0);
        #1;
        check("lit_post_cnt", 64'(fifo_count), 64'd1);
        check("lit_post_ov",  64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("lit_post_drained", 64'(fifo_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
